// File: rtl/fft8_pkg.sv
// Shared types, constants and addressing helpers for the 8-point sequential FFT.
package fft8_pkg;

    typedef enum logic [1:0] {
        LOAD,
        CALC,
        DRAIN
    } state_t;

    localparam int W8_C    = 11585;
    localparam int TW_FRAC = 14;

    typedef struct packed {
        logic [2:0] top;
        logic [2:0] bot;
        logic [1:0] widx;
    } bfly_addr_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] n);
        return {n[0], n[1], n[2]};
    endfunction

    // Butterfly step 0..11 -> stage s = step/4, k = step%4, span = 1<<s.
    function automatic bfly_addr_t bfly_addr(input logic [3:0] step);
        int unsigned s;
        int unsigned k;
        int unsigned span;
        int unsigned top;
        int unsigned widx;
        bfly_addr_t  r;
        s    = int'(step) / 4;
        k    = int'(step) % 4;
        span = 1 << s;
        top  = (k >> s) * 2 * span + (k & (span - 1));
        widx = (k & (span - 1)) << (2 - s);
        r.top  = 3'(top);
        r.bot  = 3'(top + span);
        r.widx = 2'(widx);
        return r;
    endfunction

endpackage

// File: rtl/fft8_seq_ctrl_bfly.sv
// Combinational radix-2 complex butterfly: (a + b*W8^widx, a - b*W8^widx).
// Optional per-stage halving selected by FFT8_STAGE_SCALE_EN.
module fft_bfly
    import fft8_pkg::*;
#(
    parameter int DW = 32,
    parameter int TW = 16
) (
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic        [1:0]    widx,
    output logic signed [DW-1:0] y0_re,
    output logic signed [DW-1:0] y0_im,
    output logic signed [DW-1:0] y1_re,
    output logic signed [DW-1:0] y1_im
);

    localparam int PW = DW + TW + 1;

    logic signed [PW-1:0] c_x;
    logic signed [PW-1:0] br_x;
    logic signed [PW-1:0] bi_x;
    logic signed [PW-1:0] pr;
    logic signed [PW-1:0] pi;
    logic signed [DW-1:0] t_re;
    logic signed [DW-1:0] t_im;

    assign c_x  = PW'(W8_C);
    assign br_x = PW'(b_re);
    assign bi_x = PW'(b_im);
    assign pr   = br_x * c_x;
    assign pi   = bi_x * c_x;

    // Twiddle product: W^0 bypass, W^2 swap/negate, W^1/W^3 via the single constant C.
    always_comb begin
        t_re = b_re;
        t_im = b_im;
        case (widx)
            2'd0: begin
                t_re = b_re;
                t_im = b_im;
            end
            2'd1: begin
                t_re = DW'((pr + pi) >>> TW_FRAC);
                t_im = DW'((pi - pr) >>> TW_FRAC);
            end
            2'd2: begin
                t_re = b_im;
                t_im = -b_re;
            end
            default: begin
                t_re = DW'((pi - pr) >>> TW_FRAC);
                t_im = DW'((-pr - pi) >>> TW_FRAC);
            end
        endcase
    end

`ifdef FFT8_STAGE_SCALE_EN
    // Sums are formed one bit wider so the halving never loses the carry.
    logic signed [DW:0] s0_re, s0_im, s1_re, s1_im;
    assign s0_re = {a_re[DW-1], a_re} + {t_re[DW-1], t_re};
    assign s0_im = {a_im[DW-1], a_im} + {t_im[DW-1], t_im};
    assign s1_re = {a_re[DW-1], a_re} - {t_re[DW-1], t_re};
    assign s1_im = {a_im[DW-1], a_im} - {t_im[DW-1], t_im};
    assign y0_re = DW'(s0_re >>> 1);
    assign y0_im = DW'(s0_im >>> 1);
    assign y1_re = DW'(s1_re >>> 1);
    assign y1_im = DW'(s1_im >>> 1);
`else
    assign y0_re = a_re + t_re;
    assign y0_im = a_im + t_im;
    assign y1_re = a_re - t_re;
    assign y1_im = a_im - t_im;
`endif

endmodule

// File: rtl/fft8_seq_ctrl.sv
// 8-point radix-2 DIT FFT sequencer: serial load, 12 time-shared butterflies, serial drain.
// Optional macro FFT8_STAGE_SCALE_EN enables per-stage 1/2 scaling in the butterfly.
module fft8_seq_ctrl
    import fft8_pkg::*;
#(
    parameter int DW = 32,
    parameter int TW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic        [2:0]    out_idx,
    output logic                 busy,
    output logic                 done
);

    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       last_bin;

    logic signed [DW-1:0] mem_re [8];
    logic signed [DW-1:0] mem_im [8];

    bfly_addr_t           ba;
    logic signed [DW-1:0] y0_re, y0_im, y1_re, y1_im;

    assign ba = bfly_addr(cnt);

    fft_bfly #(
        .DW(DW),
        .TW(TW)
    ) u_bfly (
        .a_re (mem_re[ba.top]),
        .a_im (mem_im[ba.top]),
        .b_re (mem_re[ba.bot]),
        .b_im (mem_im[ba.bot]),
        .widx (ba.widx),
        .y0_re(y0_re),
        .y0_im(y0_im),
        .y1_re(y1_re),
        .y1_im(y1_im)
    );

    // Next-state, counter and handshake outputs.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        last_bin  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_idx   = '0;
        out_re    = '0;
        out_im    = '0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (cnt == 4'd7) begin
                        state_nx = CALC;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 4'd1;
                    end
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == 4'd11) begin
                    state_nx = DRAIN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_idx   = cnt[2:0];
                out_re    = mem_re[cnt[2:0]];
                out_im    = mem_im[cnt[2:0]];
                if (out_ready) begin
                    if (cnt == 4'd7) begin
                        last_bin = 1'b1;
                        state_nx = LOAD;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_nx = LOAD;
                cnt_nx   = '0;
            end
        endcase
    end

    // State register, counter and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            done  <= last_bin;
        end
    end

    // Sample buffer: bit-reversed load, in-place butterfly write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
            end
        end else if (state == LOAD && in_valid) begin
            mem_re[bitrev3(cnt[2:0])] <= in_re;
            mem_im[bitrev3(cnt[2:0])] <= in_im;
        end else if (state == CALC) begin
            mem_re[ba.top] <= y0_re;
            mem_im[ba.top] <= y0_im;
            mem_re[ba.bot] <= y1_re;
            mem_im[ba.bot] <= y1_im;
        end
    end

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// Directed self-checking bench for fft8_seq_ctrl (DW=32, TW=16).
module tb_fft8_seq_ctrl;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_re;
    logic signed [31:0] in_im;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_re;
    logic signed [31:0] out_im;
    logic        [2:0]  out_idx;
    logic               busy;
    logic               done;

    int checks;
    int errors;

    logic signed [31:0] x_re [8];
    logic signed [31:0] x_im [8];
    logic signed [31:0] e_re [8];
    logic signed [31:0] e_im [8];

    fft8_seq_ctrl #(
        .DW(32),
        .TW(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_re    (in_re),
        .in_im    (in_im),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_re   (out_re),
        .out_im   (out_im),
        .out_idx  (out_idx),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_frame(input string tag);
        for (int n = 0; n < 8; n++) begin
            in_valid = 1'b1;
            in_re    = x_re[n];
            in_im    = x_im[n];
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s in_ready beat %0d: got %b want 1", tag, n, in_ready);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
    endtask

    // Drains 8 bins; stall_at >= 0 holds out_ready low 5 cycles on that bin.
    task automatic run_drain(input string tag, input int stall_at);
        int w;
        int done_cnt;
        w        = 0;
        done_cnt = 0;
        while (out_valid !== 1'b1 && w < 40) begin
            @(posedge clk);
            #1;
            w++;
            if (done === 1'b1) done_cnt++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid_timeout: got %b want 1", tag, out_valid);
        end
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (out_idx !== 3'(b) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s idx: got %0d/v%b want %0d/v1", tag, out_idx, out_valid, b);
            end
            checks++;
            if (out_re !== e_re[b] || out_im !== e_im[b]) begin
                errors++;
                $display("FAIL %s bin%0d: got (%0d,%0d) want (%0d,%0d)",
                         tag, b, out_re, out_im, e_re[b], e_im[b]);
            end
            if (b == stall_at) begin
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (out_idx !== 3'(b) || out_valid !== 1'b1 ||
                        out_re !== e_re[b] || out_im !== e_im[b]) begin
                        errors++;
                        $display("FAIL %s stall%0d: got idx %0d (%0d,%0d) v%b want idx %0d (%0d,%0d) v1",
                                 tag, c, out_idx, out_re, out_im, out_valid, b, e_re[b], e_im[b]);
                    end
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
        end
        checks++;
        if (done !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s end_state: got done %b in_ready %b busy %b want 1 1 0",
                     tag, done, in_ready, busy);
        end
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            out_idx !== 3'd0 || out_re !== 32'sd0 || out_im !== 32'sd0) begin
            errors++;
            $display("FAIL reset: got rdy%b v%b busy%b done%b idx%0d (%0d,%0d) want 1 0 0 0 0 (0,0)",
                     in_ready, out_valid, busy, done, out_idx, out_re, out_im);
        end
    endtask

    task automatic test_impulse();
        for (int n = 0; n < 8; n++) begin
            x_re[n] = (n == 0) ? 32'sd1 : 32'sd0;
            x_im[n] = '0;
            e_re[n] = 32'sd1;
            e_im[n] = '0;
        end
        send_frame("impulse");
        run_drain("impulse", -1);
    endtask

    task automatic test_dc();
        int n_edges;
        for (int n = 0; n < 8; n++) begin
            x_re[n] = 32'sd4;
            x_im[n] = '0;
            e_re[n] = (n == 0) ? 32'sd32 : 32'sd0;
            e_im[n] = '0;
        end
        send_frame("dc");
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL dc calc_flags: got busy %b in_ready %b want 1 0", busy, in_ready);
        end
        n_edges = 0;
        while (out_valid !== 1'b1 && n_edges < 40) begin
            @(posedge clk);
            #1;
            n_edges++;
        end
        // Counting the cycle that carried the last beat as cycle 0.
        checks++;
        if (n_edges + 1 != 13) begin
            errors++;
            $display("FAIL dc latency: got %0d want 13", n_edges + 1);
        end
        run_drain("dc", -1);
    endtask

    task automatic test_tone();
        x_re[0] = 32'sd16384;  x_re[1] = 32'sd11585;  x_re[2] = 32'sd0;      x_re[3] = -32'sd11585;
        x_re[4] = -32'sd16384; x_re[5] = -32'sd11585; x_re[6] = 32'sd0;      x_re[7] = 32'sd11585;
        // Hand-worked fixed-point result (floor after >>>14 of 2*C*23170).
        e_re[0] = 32'sd0;      e_re[1] = 32'sd65534;  e_re[2] = 32'sd0;      e_re[3] = 32'sd1;
        e_re[4] = 32'sd0;      e_re[5] = 32'sd2;      e_re[6] = 32'sd0;      e_re[7] = 32'sd65535;
        for (int n = 0; n < 8; n++) begin
            x_im[n] = '0;
            e_im[n] = '0;
        end
        send_frame("tone");
        run_drain("tone", -1);
    endtask

    task automatic test_backpressure();
        for (int n = 0; n < 8; n++) begin
            x_re[n] = (n == 0) ? 32'sd5 : 32'sd0;
            x_im[n] = (n == 0) ? -32'sd3 : 32'sd0;
            e_re[n] = 32'sd5;
            e_im[n] = -32'sd3;
        end
        send_frame("backpressure");
        run_drain("backpressure", 3);
    endtask

    task automatic test_reset_mid_calc();
        for (int n = 0; n < 8; n++) begin
            x_re[n] = 32'sd4;
            x_im[n] = 32'sd7;
        end
        send_frame("rst_mid");
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            out_idx !== 3'd0 || out_re !== 32'sd0 || out_im !== 32'sd0) begin
            errors++;
            $display("FAIL rst_mid outputs: got rdy%b v%b busy%b done%b idx%0d (%0d,%0d) want 1 0 0 0 0 (0,0)",
                     in_ready, out_valid, busy, done, out_idx, out_re, out_im);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 8; n++) begin
            x_re[n] = (n == 0) ? 32'sd1 : 32'sd0;
            x_im[n] = '0;
            e_re[n] = 32'sd1;
            e_im[n] = '0;
        end
        send_frame("rst_mid_next");
        run_drain("rst_mid_next", -1);
    endtask

    task automatic test_scale();
        for (int n = 0; n < 8; n++) begin
            x_re[n] = 32'sd8;
            x_im[n] = '0;
`ifdef FFT8_STAGE_SCALE_EN
            e_re[n] = (n == 0) ? 32'sd8 : 32'sd0;
`else
            e_re[n] = (n == 0) ? 32'sd64 : 32'sd0;
`endif
            e_im[n] = '0;
        end
        send_frame("scale");
        // Garbage offered while the frame is in flight must not be accepted.
        in_valid = 1'b1;
        in_re    = 32'sd999;
        in_im    = -32'sd999;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL scale in_ready_calc%0d: got %b want 0", c, in_ready);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
        run_drain("scale", -1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
`ifndef FFT8_STAGE_SCALE_EN
        test_impulse();
        test_dc();
        test_tone();
        test_backpressure();
        test_reset_mid_calc();
`endif
        test_scale();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
